// File: rtl/fifo_dma_reader.sv
// Read-side controller for the SDMAC longword FIFO (SCSI-to-memory direction).
// Drains FIFO longwords into 68030-style bus-master write cycles, retiring each entry with DECFIFO/INCNO.
module fifo_dma_reader #(
  parameter int CNT_W     = 24,
  parameter int BURST_MAX = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic             START,
  input  logic [29:0]      START_ADDR,
  input  logic [CNT_W-1:0] LW_COUNT,
  input  logic             DMAENA,
  input  logic             FIFOEMPTY,
  input  logic [31:0]      OD,
  input  logic             BGRANT,
  input  logic             DSACK,
  input  logic             BERR,
  output logic             BREQ,
  output logic             AS,
  output logic             DS,
  output logic             RW,
  output logic [29:0]      ADDR,
  output logic [31:0]      DATA_OUT,
  output logic             DECFIFO,
  output logic             INCNO,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAITF  = 3'd1,
    REQ    = 3'd2,
    ADDRP  = 3'd3,
    DATAP  = 3'd4,
    RETIRE = 3'd5,
    CHK    = 3'd6
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]    burst;
  logic [TW-1:0]    tmo;

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state    <= IDLE;
      BREQ     <= 1'b0;
      AS       <= 1'b0;
      DS       <= 1'b0;
      RW       <= 1'b1;
      ADDR     <= '0;
      DATA_OUT <= '0;
      DECFIFO  <= 1'b0;
      INCNO    <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      cnt      <= '0;
      burst    <= '0;
      tmo      <= '0;
    end else begin
      DECFIFO <= 1'b0;
      INCNO   <= 1'b0;
      DONE    <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            ADDR  <= START_ADDR;
            cnt   <= LW_COUNT;
            ERR   <= 1'b0;
            burst <= '0;
            if (LW_COUNT == '0) begin
              DONE <= 1'b1;
              BUSY <= 1'b0;
            end else begin
              BUSY  <= 1'b1;
              state <= WAITF;
            end
          end
        end
        WAITF: begin
          if (!FIFOEMPTY && DMAENA) begin
            BREQ  <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (BGRANT) begin
            DATA_OUT <= OD;
            AS       <= 1'b1;
            RW       <= 1'b0;
            state    <= ADDRP;
          end
        end
        ADDRP: begin
          DS    <= 1'b1;
          tmo   <= '0;
          state <= DATAP;
        end
        DATAP: begin
          // BERR takes priority over a simultaneous DSACK; an aborted cycle never retires its entry
          if (BERR || (tmo == TMO_LAST)) begin
            AS    <= 1'b0;
            DS    <= 1'b0;
            RW    <= 1'b1;
            BREQ  <= 1'b0;
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
            burst <= '0;
            state <= IDLE;
          end else if (DSACK) begin
            AS      <= 1'b0;
            DS      <= 1'b0;
            RW      <= 1'b1;
            DECFIFO <= 1'b1;
            INCNO   <= 1'b1;
            state   <= RETIRE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        RETIRE: begin
          ADDR  <= ADDR + 30'd1;
          cnt   <= cnt - CNT_W'(1);
          burst <= burst + BW'(1);
          state <= CHK;
        end
        CHK: begin
          // FIFOEMPTY here already reflects the entry retired in the previous cycle
          if (cnt == '0) begin
            BREQ  <= 1'b0;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            burst <= '0;
            state <= IDLE;
          end else if ((burst == BURST_LAST) || FIFOEMPTY || !DMAENA) begin
            BREQ  <= 1'b0;
            burst <= '0;
            state <= WAITF;
          end else begin
            DATA_OUT <= OD;
            AS       <= 1'b1;
            RW       <= 1'b0;
            state    <= ADDRP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_dma_reader.sv
// Directed bench for fifo_dma_reader: FIFO/slave responder model plus a linear sequence of checked steps.
module tb_fifo_dma_reader;

  logic        SCLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [29:0] START_ADDR = '0;
  logic [23:0] LW_COUNT = '0;
  logic        DMAENA = 1'b1;
  logic        FIFOEMPTY;
  logic [31:0] OD;
  logic        BGRANT = 1'b1;
  logic        DSACK = 1'b0;
  logic        BERR = 1'b0;
  logic        BREQ, AS, DS, RW, DECFIFO, INCNO, BUSY, DONE, ERR;
  logic [29:0] ADDR;
  logic [31:0] DATA_OUT;

  fifo_dma_reader #(.CNT_W(24), .BURST_MAX(8), .TIMEOUT(64)) dut (
    .SCLK(SCLK), .RST(RST), .START(START), .START_ADDR(START_ADDR), .LW_COUNT(LW_COUNT),
    .DMAENA(DMAENA), .FIFOEMPTY(FIFOEMPTY), .OD(OD), .BGRANT(BGRANT), .DSACK(DSACK), .BERR(BERR),
    .BREQ(BREQ), .AS(AS), .DS(DS), .RW(RW), .ADDR(ADDR), .DATA_OUT(DATA_OUT),
    .DECFIFO(DECFIFO), .INCNO(INCNO), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 SCLK = ~SCLK;

  // FIFO model: the initial block pushes, the responder pops on DECFIFO
  logic [31:0] fifo_mem [256];
  logic [7:0]  wr_ptr = '0;
  logic [7:0]  rd_ptr = '0;
  assign FIFOEMPTY = (wr_ptr == rd_ptr);
  assign OD = fifo_mem[rd_ptr];

  bit dsack_en = 1'b1;
  int berr_lw = -1;

  int ds_cycles = 0, last_ds_len = 0, ds_rise_n = 0;
  int dec_cnt = 0, inc_cnt = 0, done_cnt = 0, consec = 0;
  int breq_rise = 0, breq_fall = 0, as_rise = 0;
  logic prev_dec = 1'b0, prev_breq = 1'b0, prev_as = 1'b0;
  logic [7:0]  wcnt = '0;
  logic [29:0] wlog_a [256];
  logic [31:0] wlog_d [256];

  always @(negedge SCLK) begin
    if (DECFIFO) rd_ptr = rd_ptr + 8'd1;
    if (DS) ds_cycles++;
    else begin
      if (ds_cycles != 0) last_ds_len = ds_cycles;
      ds_cycles = 0;
    end
    if (DS && ds_cycles == 1) ds_rise_n++;
    DSACK = DS && dsack_en && (ds_cycles >= 2);
    BERR  = DS && (ds_rise_n == berr_lw) && (ds_cycles >= 2);
    if (DECFIFO) dec_cnt++;
    if (INCNO) inc_cnt++;
    if (DONE) done_cnt++;
    if (DECFIFO && prev_dec) consec++;
    if (BREQ && !prev_breq) breq_rise++;
    if (!BREQ && prev_breq) breq_fall++;
    if (AS && !prev_as) as_rise++;
    if (AS && DS && DSACK && !BERR) begin
      wlog_a[wcnt] = ADDR;
      wlog_d[wcnt] = DATA_OUT;
      wcnt = wcnt + 8'd1;
    end
    prev_dec = DECFIFO;
    prev_breq = BREQ;
    prev_as = AS;
  end

  int tests = 0, failed = 0;
  int s_dec, s_inc, s_done, s_brise, s_bfall, s_as;
  logic [7:0] s_w;

  task automatic tick();
    @(negedge SCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic snap();
    s_dec = dec_cnt; s_inc = inc_cnt; s_done = done_cnt;
    s_brise = breq_rise; s_bfall = breq_fall; s_as = as_rise; s_w = wcnt;
  endtask

  task automatic start(input logic [29:0] a, input logic [23:0] n);
    START_ADDR = a;
    LW_COUNT = n;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < max) begin
      tick();
      n++;
    end
    check("wait_idle_bound", 64'(n < max), 64'd1);
    tick();
  endtask

  function automatic logic [7:0] widx(input int k);
    return s_w + 8'(k);
  endfunction

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_breq", BREQ, 0);
    check("rst_as", AS, 0);
    check("rst_ds", DS, 0);
    check("rst_rw", RW, 1);
    check("rst_addr", ADDR, 0);
    check("rst_data", DATA_OUT, 0);
    check("rst_dec", DECFIFO, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    RST = 1'b0;
    tick();

    // Basic three-longword transfer
    push(32'h11111111); push(32'h22222222); push(32'h33333333);
    snap();
    start(30'h100, 24'd3);
    check("t1_busy", BUSY, 1);
    wait_idle(200);
    check("t1_writes", wcnt - s_w, 3);
    check("t1_a0", wlog_a[widx(0)], 30'h100);
    check("t1_d0", wlog_d[widx(0)], 32'h11111111);
    check("t1_a1", wlog_a[widx(1)], 30'h101);
    check("t1_d1", wlog_d[widx(1)], 32'h22222222);
    check("t1_a2", wlog_a[widx(2)], 30'h102);
    check("t1_d2", wlog_d[widx(2)], 32'h33333333);
    check("t1_dec", dec_cnt - s_dec, 3);
    check("t1_inc", inc_cnt - s_inc, 3);
    check("t1_done", done_cnt - s_done, 1);
    check("t1_busy_end", BUSY, 0);
    check("t1_err", ERR, 0);
    check("t1_rw_idle", RW, 1);

    // Twenty longwords, burst limit forces two re-requests
    for (int i = 0; i < 20; i++) push(32'hA0000000 + 32'(i));
    snap();
    start(30'h2000, 24'd20);
    wait_idle(1000);
    check("t2_dec", dec_cnt - s_dec, 20);
    check("t2_breq_rise", breq_rise - s_brise, 3);
    check("t2_breq_fall", breq_fall - s_bfall, 3);
    check("t2_a8", wlog_a[widx(8)], 30'h2008);
    check("t2_a19", wlog_a[widx(19)], 30'h2013);
    check("t2_d19", wlog_d[widx(19)], 32'hA0000013);
    check("t2_addr", ADDR, 30'h2014);
    check("t2_done", done_cnt - s_done, 1);

    // FIFO runs dry after two entries, controller parks in WAITF
    push(32'h51); push(32'h52);
    snap();
    start(30'h300, 24'd5);
    for (int n = 0; n < 200 && (wcnt - s_w) < 2; n++) tick();
    repeat (10) tick();
    check("t3_park_writes", wcnt - s_w, 2);
    check("t3_park_busy", BUSY, 1);
    check("t3_park_breq", BREQ, 0);
    check("t3_park_as", AS, 0);
    push(32'h53); push(32'h54); push(32'h55);
    wait_idle(300);
    check("t3_writes", wcnt - s_w, 5);
    check("t3_a4", wlog_a[widx(4)], 30'h304);
    check("t3_d4", wlog_d[widx(4)], 32'h55);
    check("t3_breq_rise", breq_rise - s_brise, 2);
    check("t3_done", done_cnt - s_done, 1);

    // BERR (with a simultaneous DSACK) on the second longword
    push(32'h41414141); push(32'h42424242); push(32'h43434343);
    snap();
    berr_lw = ds_rise_n + 2;
    start(30'h500, 24'd3);
    for (int n = 0; n < 200 && BERR !== 1'b1; n++) tick();
    check("t4_berr_seen", BERR, 1);
    tick();
    check("t4_as", AS, 0);
    check("t4_ds", DS, 0);
    check("t4_breq", BREQ, 0);
    check("t4_err", ERR, 1);
    check("t4_busy", BUSY, 0);
    check("t4_dec", dec_cnt - s_dec, 1);
    check("t4_addr", ADDR, 30'h501);
    check("t4_done", done_cnt - s_done, 0);
    berr_lw = -1;

    // DSACK withheld: abort after 64 data-phase cycles
    dsack_en = 1'b0;
    snap();
    start(30'h600, 24'd2);
    check("t5_err_cleared", ERR, 0);
    wait_idle(300);
    check("t5_err", ERR, 1);
    check("t5_ds_len", last_ds_len, 64);
    check("t5_dec", dec_cnt - s_dec, 0);
    check("t5_addr", ADDR, 30'h600);
    check("t5_data", DATA_OUT, 32'h42424242);
    check("t5_breq", BREQ, 0);
    dsack_en = 1'b1;

    // Address wrap at the top of the longword space
    snap();
    start(30'h3FFFFFFF, 24'd2);
    wait_idle(200);
    check("t6_a0", wlog_a[widx(0)], 30'h3FFFFFFF);
    check("t6_d0", wlog_d[widx(0)], 32'h42424242);
    check("t6_a1", wlog_a[widx(1)], 30'h0);
    check("t6_d1", wlog_d[widx(1)], 32'h43434343);
    check("t6_addr", ADDR, 30'h1);
    check("t6_err", ERR, 0);

    // Zero-length transfer
    snap();
    start(30'h123, 24'd0);
    check("t7_done", DONE, 1);
    check("t7_busy", BUSY, 0);
    repeat (5) tick();
    check("t7_done_once", done_cnt - s_done, 1);
    check("t7_no_breq", breq_rise - s_brise, 0);

    // START while busy is ignored
    BGRANT = 1'b0;
    push(32'h71); push(32'h72);
    snap();
    start(30'h700, 24'd2);
    repeat (3) tick();
    check("t8_breq_wait", BREQ, 1);
    start(30'h900, 24'd5);
    check("t8_addr_kept", ADDR, 30'h700);
    BGRANT = 1'b1;
    wait_idle(200);
    check("t8_writes", wcnt - s_w, 2);
    check("t8_a0", wlog_a[widx(0)], 30'h700);
    check("t8_addr", ADDR, 30'h702);
    check("t8_dec", dec_cnt - s_dec, 2);

    // Reset in the middle of a data phase
    dsack_en = 1'b0;
    push(32'h81); push(32'h82);
    snap();
    start(30'h800, 24'd2);
    for (int n = 0; n < 50 && DS !== 1'b1; n++) tick();
    check("t9_ds_high", DS, 1);
    RST = 1'b1;
    tick();
    check("t9_as", AS, 0);
    check("t9_ds", DS, 0);
    check("t9_breq", BREQ, 0);
    check("t9_rw", RW, 1);
    check("t9_addr", ADDR, 0);
    check("t9_busy", BUSY, 0);
    check("t9_dec", dec_cnt - s_dec, 0);
    RST = 1'b0;
    dsack_en = 1'b1;
    tick();

    check("no_back_to_back_dec", consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
